// File: rtl/spi_ctrl_pkg.sv
// Shared types and sizing helpers for the SPI slave transaction controller.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HDR       = 3'd1,
    ST_DECODE    = 3'd2,
    ST_RD_LOAD   = 3'd3,
    ST_RD_SHIFT  = 3'd4,
    ST_WR_SHIFT  = 3'd5,
    ST_WR_COMMIT = 3'd6,
    ST_WAIT_CS   = 3'd7
  } state_e;

  // Wide enough to hold the longest segment length (header or data word).
  function automatic int cnt_width(input int addr_w, input int data_w);
    int span;
    span = ((addr_w + 1) > data_w) ? (addr_w + 1) : data_w;
    return $clog2(span + 1);
  endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// Strobe counter with synchronous clear and terminal-count flag against a runtime limit.
module spi_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  // High while the next strobe is the last one of the segment.
  assign tc_o  = (cnt_q == (limit_i - CNT_W'(1)));

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Transaction sequencer for the SPI memory slave: header decode, read load/shift,
// write commit, optional burst auto-increment and clean abort on early CS release.
module spi_xfer_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int BURST_EN = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_rise,
  input  logic cs,
  input  logic lsbsrop,
  output logic addr_we,
  output logic sr_we,
  output logic dm_we,
  output logic miso_bufe,
  output logic addr_inc,
  output logic abort,
  output logic busy
);

  localparam int               CNT_W    = cnt_width(ADDR_W, DATA_W);
  localparam logic [CNT_W-1:0] HDR_LEN  = CNT_W'(ADDR_W + 1);
  localparam logic [CNT_W-1:0] WORD_LEN = CNT_W'(DATA_W);
  localparam logic             BURST    = (BURST_EN != 0);

  state_e state_q, state_d;
  logic addr_we_q, addr_we_d, sr_we_q, sr_we_d, dm_we_q, dm_we_d;
  logic miso_bufe_q, miso_bufe_d, addr_inc_q, addr_inc_d;
  logic abort_q, abort_d, busy_q, busy_d;

  logic             cnt_clr_s, cnt_en_s, cnt_tc_s, last_s;
  logic [CNT_W-1:0] cnt_lim_s, cnt_s;

  assign cnt_lim_s = (state_q == ST_HDR) ? HDR_LEN : WORD_LEN;
  assign cnt_en_s  = sclk_rise && ((state_q == ST_HDR) || (state_q == ST_RD_SHIFT) ||
                                   (state_q == ST_WR_SHIFT));
  assign last_s    = sclk_rise && cnt_tc_s;

  spi_bit_counter #(.CNT_W(CNT_W)) u_bit_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (cnt_clr_s),
    .en_i    (cnt_en_s),
    .limit_i (cnt_lim_s),
    .cnt_o   (cnt_s),
    .tc_o    (cnt_tc_s)
  );

  // Next state and next registered outputs; CS release overrides every active state.
  always_comb begin
    state_d     = state_q;
    addr_we_d   = 1'b0;
    sr_we_d     = 1'b0;
    dm_we_d     = 1'b0;
    miso_bufe_d = 1'b0;
    addr_inc_d  = 1'b0;
    abort_d     = 1'b0;
    cnt_clr_s   = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!cs) state_d = ST_HDR;
        else     state_d = ST_IDLE;
      end
      ST_WAIT_CS: begin
        if (cs) state_d = ST_IDLE;
        else    state_d = ST_WAIT_CS;
      end
      default: begin
        if (cs) begin
          state_d = ST_IDLE;
          abort_d = (cnt_s != {CNT_W{1'b0}});
        end else begin
          case (state_q)
            ST_HDR: begin
              cnt_clr_s = last_s;
              if (last_s) begin
                addr_we_d = 1'b1;
                state_d   = ST_DECODE;
              end else begin
                state_d   = ST_HDR;
              end
            end
            ST_DECODE: begin
              if (lsbsrop) state_d = ST_RD_LOAD;
              else         state_d = ST_WR_SHIFT;
            end
            ST_RD_LOAD: begin
              sr_we_d = 1'b1;
              state_d = ST_RD_SHIFT;
            end
            ST_RD_SHIFT: begin
              cnt_clr_s = last_s;
              if (last_s) begin
                addr_inc_d = BURST;
                state_d    = BURST ? ST_RD_LOAD : ST_WAIT_CS;
              end else begin
                miso_bufe_d = 1'b1;
                state_d     = ST_RD_SHIFT;
              end
            end
            ST_WR_SHIFT: begin
              cnt_clr_s  = last_s;
              // Burst increment trails the commit pulse by one clock.
              addr_inc_d = BURST && dm_we_q;
              if (last_s) state_d = ST_WR_COMMIT;
              else        state_d = ST_WR_SHIFT;
            end
            ST_WR_COMMIT: begin
              dm_we_d = 1'b1;
              state_d = BURST ? ST_WR_SHIFT : ST_WAIT_CS;
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_we_q   <= 1'b0;
      sr_we_q     <= 1'b0;
      dm_we_q     <= 1'b0;
      miso_bufe_q <= 1'b0;
      addr_inc_q  <= 1'b0;
      abort_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_we_q   <= addr_we_d;
      sr_we_q     <= sr_we_d;
      dm_we_q     <= dm_we_d;
      miso_bufe_q <= miso_bufe_d;
      addr_inc_q  <= addr_inc_d;
      abort_q     <= abort_d;
      busy_q      <= busy_d;
    end
  end

  assign addr_we   = addr_we_q;
  assign sr_we     = sr_we_q;
  assign dm_we     = dm_we_q;
  assign miso_bufe = miso_bufe_q;
  assign addr_inc  = addr_inc_q;
  assign abort     = abort_q;
  assign busy      = busy_q;

endmodule

// File: doc/spi_xfer_ctrl.md
# spi_xfer_ctrl

Parametrised control FSM for the SPI memory slave: the successor to the fixed 8-bit transaction controller. It sequences the address latch, shift-register parallel load, data-memory write enable and MISO tri-state buffer. It sits between the input conditioners (synchronised `cs`, one-clock `sclk_rise` strobe) and the datapath (shift register, address latch, data memory). New behaviour over the previous generation:

- configurable address/data widths
- burst mode with address auto-increment
- clean abort on mid-frame CS release
- hold-off until CS returns high

## Interface
Parameters:
- `ADDR_W`, default 7: address bits in header; header length = ADDR_W+1 (address + R/W bit, R/W last)
- `DATA_W`, default 8: data bits per word
- `BURST_EN`, default 0: 1 = multiple words per CS assertion with address auto-increment

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `sclk_rise`  in  1  conditioned SCLK rising-edge strobe, one `clk` wide
- `cs`  in  1  conditioned chip select, active low
- `lsbsrop`  in  1  shift-register LSB = R/W bit (1 = read, 0 = write), valid after header
- `addr_we`  out  1  address-latch write enable, 1-clk pulse
- `sr_we`  out  1  shift-register parallel-load enable, 1-clk pulse
- `dm_we`  out  1  data-memory write enable, 1-clk pulse
- `miso_bufe`  out  1  MISO buffer enable, level
- `addr_inc`  out  1  address-latch increment, 1-clk pulse (BURST_EN only)
- `abort`  out  1  partial frame discarded, 1-clk pulse
- `busy`  out  1  state != IDLE

## Operation
- All outputs are registered. Reset forces state IDLE, bit counter 0, and every output 0.
- States: IDLE, HDR, DECODE, RD_LOAD, RD_SHIFT, WR_SHIFT, WR_COMMIT, WAIT_CS.
- IDLE: outputs 0. `cs`==0 → HDR, counter cleared.
- HDR: count `sclk_rise`. On the (ADDR_W+1)th strobe → DECODE; pulse `addr_we`; clear counter.
- DECODE (one clk, no strobe needed): `lsbsrop`=1 → RD_LOAD; otherwise → WR_SHIFT.
- RD_LOAD (one clk): pulse `sr_we` → RD_SHIFT.
- RD_SHIFT: `miso_bufe`=1. Count DATA_W strobes. On the last strobe, `miso_bufe`→0 and:
  - BURST_EN=1: pulse `addr_inc` → RD_LOAD.
  - BURST_EN=0: → WAIT_CS.
- WR_SHIFT: count DATA_W strobes. On the last strobe → WR_COMMIT.
- WR_COMMIT (one clk): pulse `dm_we`. Then:
  - BURST_EN=1: pulse `addr_inc` in the following clk → WR_SHIFT.
  - BURST_EN=0: → WAIT_CS.
- WAIT_CS: outputs 0. Ignore strobes. `cs`==1 → IDLE.
- Abort: `cs`==1 in any state other than IDLE/WAIT_CS → IDLE next clk. All level outputs 0, counter 0.
  - Pulse `abort` if the counter was nonzero (partial header or word).
  - A partial write word is never committed.
- Simultaneous `cs` rise and final data strobe in WR_SHIFT: abort wins; no `dm_we`; `abort`=1.
- Width rules:
  - Counter width = $clog2(max(ADDR_W+1, DATA_W)+1).
  - Counter compare is exact equality; it never wraps during a frame.
- Reset mid-operation: immediate return to IDLE, all outputs 0, no pulse completes.

## Timing
- A strobe sampled in clk t produces its pulse/level change in clk t+1.
- Header end: `addr_we` at t+1; `sr_we` at t+3 (read); `miso_bufe` high from t+4.
- Write commit: `dm_we` at t+2 after the final data strobe.
- Burst turnaround:
  - Read: `addr_inc` at t+1, `sr_we` at t+2, `miso_bufe` at t+3.
  - Write: `addr_inc` at t+3.
- Required input spacing: `sclk_rise` strobes ≥4 clk apart. Behaviour is unspecified below that.
- Pulses are never wider than one clk. `addr_we`, `sr_we`, `dm_we` and `addr_inc` are mutually exclusive in any clk.
- Abort latency: 1 clk from `cs` high to IDLE with outputs cleared.

## Structure
- Package `spi_ctrl_pkg`: state enum/localparams and a counter-width helper function.
- Sub-module `spi_bit_counter`: clear, enable on strobe, terminal-count compare against a runtime limit of ADDR_W+1 or DATA_W.

## Test plan
- Read, defaults: cs low; 8 strobes with R/W=1 → `addr_we` 1 clk after 8th strobe, `sr_we` 2 clk later, `miso_bufe` high for 8 strobes then 0; WAIT_CS until cs high.
- Write, defaults: header R/W=0, then 8 strobes → exactly one `dm_we` pulse 2 clk after 8th strobe; no `sr_we`, `miso_bufe` stays 0.
- Burst write, BURST_EN=1, ADDR_W=15, DATA_W=16: 16 header + 3×16 data strobes → 3 `dm_we`, 3 `addr_inc`, 1 `addr_we`.
- Abort: cs high after 5 of 8 write data strobes → `abort` 1 clk, no `dm_we`, `busy`=0 next clk.
- Abort/commit collision: cs rises in the same clk as the 8th write strobe → no `dm_we`, `abort`=1.
- Async reset asserted mid RD_SHIFT → all outputs 0 immediately; after release, IDLE; a fresh frame decodes correctly.
